// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: memory function/type codes
// and the arbiter FSM state/owner encodings.
package mem_port_arbiter_pkg;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } t_m;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_D  = 3'd4,
    MT_BU = 3'd5,
    MT_HU = 3'd6,
    MT_WU = 3'd7
  } t_mt;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } t_arb_state;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } t_arb_owner;

  // Halfwords must sit on even addresses, full words (MT_W only) on word addresses.
  function automatic logic is_misaligned(input t_mt typ, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (typ)
      MT_H, MT_HU: bad = a[0];
      MT_W:        bad = (a != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores (byte enables + replication) and
// byte/half extraction with sign/zero extension for loads.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  t_mt              typ,
  input  logic [1:0]       addr_lo,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [3:0]       be,
  output logic [XLEN-1:0]  wdata_steered,
  output logic [XLEN-1:0]  rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    be            = 4'hF;
    wdata_steered = wdata;
    case (typ)
      MT_B: begin
        be            = 4'b0001 << addr_lo;
        wdata_steered = {(XLEN/8){wdata[7:0]}};
      end
      MT_H: begin
        be            = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_steered = {(XLEN/16){wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword selection ignores addr_lo[0], so misaligned halves read the aligned half.
  always_comb begin
    rd_byte   = rdata[{addr_lo, 3'b000} +: 8];
    rd_half   = rdata[{addr_lo[1], 4'b0000} +: 16];
    rdata_ext = rdata;
    case (typ)
      MT_B:    rdata_ext = {{(XLEN-8){rd_byte[7]}}, rd_byte};
      MT_BU:   rdata_ext = {{(XLEN-8){1'b0}}, rd_byte};
      MT_H:    rdata_ext = {{(XLEN-16){rd_half[15]}}, rd_half};
      MT_HU:   rdata_ext = {{(XLEN-16){1'b0}}, rd_half};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and D requesters onto one memory port, one transaction at a time.
// Optional MEM_PORT_ARBITER_ALIGN_CHECK_EN adds d_resp_err and faults misaligned D accesses.
//
// Handshake: a request is accepted in the cycle its valid and ready are both high;
// ready is only ever high in IDLE and only for the arbitration winner. mem_req is held
// with stable fields until mem_gnt; exactly one mem_rvalid follows each grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [XLEN-1:0]   if_resp_data,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  t_m                d_req_fcn,
  input  t_mt               d_req_typ,
  input  logic [XLEN-1:0]   d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [XLEN-1:0]   d_resp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  output logic              d_resp_err,
`endif
  output t_arb_state        dbg_state
);

  t_arb_state        state;
  t_arb_owner        owner;
  t_arb_owner        last_owner;
  logic [ADDR_W-1:0] lat_addr;
  t_mt               lat_typ;
  logic              lat_we;
  logic [XLEN-1:0]   lat_wdata;

  logic              d_win;
  logic              if_win;
  logic [3:0]        align_be;
  logic [XLEN-1:0]   align_wdata;
  logic [XLEN-1:0]   align_rdata;

  // Last-grant-loses on a tie; last_owner resets to OWN_IF so D wins the first tie.
  assign d_win  = !rst && (state == IDLE) && d_req_valid &&
                  (!if_req_valid || (last_owner == OWN_IF));
  assign if_win = !rst && (state == IDLE) && if_req_valid && !d_win;

  assign d_req_ready  = d_win;
  assign if_req_ready = if_win;
  assign dbg_state    = state;

  mem_lane_align #(.XLEN(XLEN)) u_lane_align (
    .typ           (lat_typ),
    .addr_lo       (lat_addr[1:0]),
    .wdata         (lat_wdata),
    .rdata         (mem_rdata),
    .be            (align_be),
    .wdata_steered (align_wdata),
    .rdata_ext     (align_rdata)
  );

  assign mem_we    = mem_req && lat_we;
  assign mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
  assign mem_be    = mem_req ? (lat_we ? align_be : 4'hF) : 4'h0;
  assign mem_wdata = (mem_req && lat_we) ? align_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      last_owner    <= OWN_IF;
      lat_addr      <= '0;
      lat_typ       <= MT_X;
      lat_we        <= 1'b0;
      lat_wdata     <= '0;
      mem_req       <= 1'b0;
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      d_resp_valid  <= 1'b0;
      d_resp_data   <= '0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
      d_resp_err    <= 1'b0;
`endif
    end else begin
      if_resp_valid <= 1'b0;
      d_resp_valid  <= 1'b0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
      d_resp_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (d_win) begin
            owner     <= OWN_D;
            lat_addr  <= d_req_addr;
            lat_typ   <= d_req_typ;
            lat_we    <= (d_req_fcn == M_XWR);
            lat_wdata <= d_req_wdata;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
            if (is_misaligned(d_req_typ, d_req_addr[1:0])) begin
              state        <= RESP;
              d_resp_valid <= 1'b1;
              d_resp_err   <= 1'b1;
              d_resp_data  <= '0;
            end else begin
              state   <= REQ;
              mem_req <= 1'b1;
            end
`else
            state   <= REQ;
            mem_req <= 1'b1;
`endif
          end else if (if_win) begin
            owner     <= OWN_IF;
            lat_addr  <= if_req_addr;
            lat_typ   <= MT_W;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            state     <= REQ;
            mem_req   <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= RESP;
            if (owner == OWN_IF) begin
              if_resp_valid <= 1'b1;
              if_resp_data  <= mem_rdata;
            end else begin
              d_resp_valid <= 1'b1;
              d_resp_data  <= lat_we ? '0 : align_rdata;
            end
          end
        end
        RESP: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; covers MEM_PORT_ARBITER_ALIGN_CHECK_EN when defined.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        d_req_valid = 1'b0;
  logic [31:0] d_req_addr = '0;
  t_m          d_req_fcn = M_XRD;
  t_mt         d_req_typ = MT_W;
  logic [31:0] d_req_wdata = '0;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
  logic        d_resp_err;
`endif
  t_arb_state  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.XLEN(32), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_addr   (if_req_addr),
    .if_req_ready  (if_req_ready),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .d_req_valid   (d_req_valid),
    .d_req_addr    (d_req_addr),
    .d_req_fcn     (d_req_fcn),
    .d_req_typ     (d_req_typ),
    .d_req_wdata   (d_req_wdata),
    .d_req_ready   (d_req_ready),
    .d_resp_valid  (d_resp_valid),
    .d_resp_data   (d_resp_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    .d_resp_err    (d_resp_err),
`endif
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // The memory model must never return data in its own grant cycle.
  always @(negedge clk) begin
    if (!rst && mem_req && mem_gnt && mem_rvalid) begin
      errors++;
      $display("FAIL mem_protocol: rvalid in grant cycle at %0t", $time);
    end
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Called in the cycle the DUT shows mem_req; returns in the response cycle.
  task automatic serve(input logic [31:0] rdata);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
  endtask

  // Drives a D request in IDLE and returns in the following cycle with valid dropped.
  task automatic d_issue(input t_m fcn, input t_mt typ, input logic [31:0] addr,
                         input logic [31:0] wdata);
    d_req_valid = 1'b1;
    d_req_fcn = fcn;
    d_req_typ = typ;
    d_req_addr = addr;
    d_req_wdata = wdata;
    tick();
    d_req_valid = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset;
    apply_reset();
    #1;
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    checks++; if ({mem_req, mem_we, mem_be} !== 6'b0) begin errors++; $display("FAIL reset_mem_ctl: got %b want 000000", {mem_req, mem_we, mem_be}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
    checks++; if ({if_resp_valid, d_resp_valid, if_req_ready, d_req_ready} !== 4'b0) begin errors++; $display("FAIL reset_handshake: got %b want 0000", {if_resp_valid, d_resp_valid, if_req_ready, d_req_ready}); end
    checks++; if ({if_resp_data, d_resp_data} !== 64'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", {if_resp_data, d_resp_data}); end
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    checks++; if (d_resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", d_resp_err); end
`endif
  endtask

  task automatic test_fetch_only;
    apply_reset();
    if_req_valid = 1'b1;
    if_req_addr = 32'h100;
    mem_gnt = 1'b1;
    #1;
    checks++; if ({if_req_ready, d_req_ready} !== 2'b10) begin errors++; $display("FAIL fetch_ready: got %b want 10", {if_req_ready, d_req_ready}); end
    tick();  // t1
    if_req_valid = 1'b0;
    checks++; if ({mem_req, mem_we, mem_be} !== 6'b10_1111) begin errors++; $display("FAIL fetch_mem_ctl: got %b want 101111", {mem_req, mem_we, mem_be}); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr); end
    tick();  // t2
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0050_0093;
    checks++; if ({mem_req, if_resp_valid} !== 2'b00) begin errors++; $display("FAIL fetch_t2: got %b want 00", {mem_req, if_resp_valid}); end
    tick();  // t3
    mem_rvalid = 1'b0;
    checks++; if (if_resp_valid !== 1'b1) begin errors++; $display("FAIL fetch_resp_valid: got %b want 1", if_resp_valid); end
    checks++; if (if_resp_data !== 32'h0050_0093) begin errors++; $display("FAIL fetch_resp_data: got %h want 00500093", if_resp_data); end
    checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL fetch_no_d_resp: got %b want 0", d_resp_valid); end
    tick();  // t4
    checks++; if ({if_resp_valid, dbg_state} !== {1'b0, IDLE}) begin errors++; $display("FAIL fetch_t4: got %b want %b", {if_resp_valid, dbg_state}, {1'b0, IDLE}); end
  endtask

  task automatic test_arbitration;
    apply_reset();
    if_req_valid = 1'b1;
    if_req_addr = 32'h300;
    d_req_valid = 1'b1;
    d_req_fcn = M_XRD;
    d_req_typ = MT_W;
    d_req_addr = 32'h200;
    #1;
    checks++; if ({if_req_ready, d_req_ready} !== 2'b01) begin errors++; $display("FAIL tie1_ready: got %b want 01", {if_req_ready, d_req_ready}); end
    tick();
    d_req_valid = 1'b0;
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL tie1_addr: got %h want 00000200", mem_addr); end
    serve(32'h1111_1111);
    checks++; if ({d_resp_valid, if_resp_valid} !== 2'b10) begin errors++; $display("FAIL tie1_resp: got %b want 10", {d_resp_valid, if_resp_valid}); end
    checks++; if (d_resp_data !== 32'h1111_1111) begin errors++; $display("FAIL tie1_data: got %h want 11111111", d_resp_data); end
    tick();  // back to IDLE; D won last, so IF wins this tie
    d_req_valid = 1'b1;
    d_req_addr = 32'h204;
    #1;
    checks++; if ({if_req_ready, d_req_ready} !== 2'b10) begin errors++; $display("FAIL tie2_ready: got %b want 10", {if_req_ready, d_req_ready}); end
    tick();
    if_req_valid = 1'b0;
    checks++; if (mem_addr !== 32'h300) begin errors++; $display("FAIL tie2_addr: got %h want 00000300", mem_addr); end
    serve(32'h2222_2222);
    checks++; if ({if_resp_valid, if_resp_data} !== {1'b1, 32'h2222_2222}) begin errors++; $display("FAIL tie2_resp: got %h want 122222222", {if_resp_valid, if_resp_data}); end
    tick();
    if_req_valid = 1'b1;
    #1;
    checks++; if ({if_req_ready, d_req_ready} !== 2'b01) begin errors++; $display("FAIL tie3_ready: got %b want 01", {if_req_ready, d_req_ready}); end
    tick();
    d_req_valid = 1'b0;
    if_req_valid = 1'b0;
    checks++; if (mem_addr !== 32'h204) begin errors++; $display("FAIL tie3_addr: got %h want 00000204", mem_addr); end
    serve(32'h3333_3333);
    tick();
  endtask

  task automatic test_stores;
    t_mt         typs[5]  = '{MT_B, MT_B, MT_H, MT_H, MT_W};
    logic [31:0] addrs[5] = '{32'h203, 32'h200, 32'h202, 32'h200, 32'h204};
    logic [31:0] wd[5]    = '{32'h1234_56AB, 32'h0000_00CD, 32'h0000_BEEF, 32'hFFFF_1234, 32'hCAFE_F00D};
    logic [3:0]  ebe[5]   = '{4'b1000, 4'b0001, 4'b1100, 4'b0011, 4'b1111};
    logic [31:0] ewd[5]   = '{32'hABAB_ABAB, 32'hCDCD_CDCD, 32'hBEEF_BEEF, 32'h1234_1234, 32'hCAFE_F00D};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      d_issue(M_XWR, typs[i], addrs[i], wd[i]);
      checks++; if ({mem_req, mem_we, mem_be} !== {2'b11, ebe[i]}) begin errors++; $display("FAIL store%0d_ctl: got %b want %b", i, {mem_req, mem_we, mem_be}, {2'b11, ebe[i]}); end
      checks++; if (mem_addr !== (addrs[i] & 32'hFFFF_FFFC)) begin errors++; $display("FAIL store%0d_addr: got %h want %h", i, mem_addr, addrs[i] & 32'hFFFF_FFFC); end
      checks++; if (mem_wdata !== ewd[i]) begin errors++; $display("FAIL store%0d_wdata: got %h want %h", i, mem_wdata, ewd[i]); end
      serve(32'hDEAD_BEEF);
      checks++; if ({d_resp_valid, d_resp_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL store%0d_resp: got %h want 100000000", i, {d_resp_valid, d_resp_data}); end
      tick();
      checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL store%0d_pulse: got %b want 0", i, d_resp_valid); end
    end
  endtask

  task automatic test_loads;
    t_mt         typs[7]  = '{MT_H, MT_HU, MT_B, MT_B, MT_BU, MT_H, MT_W};
    logic [31:0] addrs[7] = '{32'h202, 32'h202, 32'h201, 32'h203, 32'h203, 32'h200, 32'h20C};
    logic [31:0] exp[7]   = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_0012, 32'hFFFF_FF80,
                              32'h0000_0080, 32'h0000_1234, 32'h8001_1234};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      d_issue(M_XRD, typs[i], addrs[i], 32'h5555_5555);
      checks++; if ({mem_req, mem_we, mem_be} !== 6'b10_1111) begin errors++; $display("FAIL load%0d_ctl: got %b want 101111", i, {mem_req, mem_we, mem_be}); end
      serve(32'h8001_1234);
      checks++; if ({d_resp_valid, d_resp_data} !== {1'b1, exp[i]}) begin errors++; $display("FAIL load%0d_resp: got %h want %h", i, {d_resp_valid, d_resp_data}, {1'b1, exp[i]}); end
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
      checks++; if (d_resp_err !== 1'b0) begin errors++; $display("FAIL load%0d_err: got %b want 0", i, d_resp_err); end
`endif
      tick();
    end
  endtask

  task automatic test_stall_and_abort;
    apply_reset();
    d_issue(M_XRD, MT_W, 32'h240, 32'h0);
    d_req_valid = 1'b1;
    d_req_addr = 32'h3FC;
    d_req_fcn = M_XWR;
    if_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({mem_req, mem_we, mem_be, mem_addr} !== {2'b10, 4'hF, 32'h240}) begin errors++; $display("FAIL stall%0d_fields: got %h want %h", i, {mem_req, mem_we, mem_be, mem_addr}, {2'b10, 4'hF, 32'h240}); end
      checks++; if ({if_req_ready, d_req_ready} !== 2'b00) begin errors++; $display("FAIL stall%0d_ready: got %b want 00", i, {if_req_ready, d_req_ready}); end
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    d_req_valid = 1'b0;
    if_req_valid = 1'b0;
    checks++; if (dbg_state !== WAIT) begin errors++; $display("FAIL abort_in_wait: got %0d want %0d", dbg_state, WAIT); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 1'b0;
    checks++; if ({d_resp_valid, if_resp_valid, mem_req} !== 3'b000) begin errors++; $display("FAIL abort_no_resp: got %b want 000", {d_resp_valid, if_resp_valid, mem_req}); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL abort_idle: got %0d want %0d", dbg_state, IDLE); end
    tick();
    checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL abort_late: got %b want 0", d_resp_valid); end
  endtask

  task automatic test_misaligned;
    apply_reset();
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    d_req_valid = 1'b1;
    d_req_fcn = M_XRD;
    d_req_typ = MT_W;
    d_req_addr = 32'h101;
    #1;
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL mis_w_ready: got %b want 1", d_req_ready); end
    tick();  // t1
    d_req_valid = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_w_no_req: got %b want 0", mem_req); end
    checks++; if ({d_resp_valid, d_resp_err, d_resp_data} !== {2'b11, 32'h0}) begin errors++; $display("FAIL mis_w_resp: got %h want 300000000", {d_resp_valid, d_resp_err, d_resp_data}); end
    tick();
    checks++; if ({d_resp_valid, d_resp_err, mem_req, dbg_state} !== {3'b000, IDLE}) begin errors++; $display("FAIL mis_w_after: got %b want %b", {d_resp_valid, d_resp_err, mem_req, dbg_state}, {3'b000, IDLE}); end
    d_issue(M_XWR, MT_HU, 32'h203, 32'h1);
    checks++; if ({mem_req, d_resp_valid, d_resp_err} !== 3'b011) begin errors++; $display("FAIL mis_h_resp: got %b want 011", {mem_req, d_resp_valid, d_resp_err}); end
    tick();
`else
    d_issue(M_XRD, MT_W, 32'h101, 32'h0);
    checks++; if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'hF, 32'h100}) begin errors++; $display("FAIL mis_w_fields: got %h want %h", {mem_req, mem_be, mem_addr}, {1'b1, 4'hF, 32'h100}); end
    serve(32'hA5A5_0001);
    checks++; if ({d_resp_valid, d_resp_data} !== {1'b1, 32'hA5A5_0001}) begin errors++; $display("FAIL mis_w_resp: got %h want 1a5a50001", {d_resp_valid, d_resp_data}); end
    tick();
    d_issue(M_XRD, MT_H, 32'h203, 32'h0);
    serve(32'h8001_1234);
    checks++; if ({d_resp_valid, d_resp_data} !== {1'b1, 32'hFFFF_8001}) begin errors++; $display("FAIL mis_h_resp: got %h want 1ffff8001", {d_resp_valid, d_resp_data}); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_arbitration();
    test_stores();
    test_loads();
    test_stall_and_abort();
    test_misaligned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the rv32 1-stage core between instruction fetch (IF) and the data/LSU path (D).
- Owns one outstanding memory transaction at a time and sequences it: accept, issue, wait, respond.
- Handles sub-word store lane steering (byte enables, data replication) and load extraction/extension per t_mt.
- Sits between core datapath and the memory model/bus.

Parameters:
- XLEN, 32, data and address width.
- ADDR_W, 32, width of request and memory addresses.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch address; word-aligned, low 2 bits ignored.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_resp_valid  out  1  one-cycle fetch response pulse.
- if_resp_data  out  XLEN  instruction word.
- d_req_valid  in  1  data request.
- d_req_addr  in  ADDR_W  byte address.
- d_req_fcn  in  t_m  M_XRD load, M_XWR store.
- d_req_typ  in  t_mt  access size and signedness.
- d_req_wdata  in  XLEN  store data, LSB-aligned.
- d_req_ready  out  1  data request accepted this cycle.
- d_resp_valid  out  1  one-cycle data response pulse; also issued for stores.
- d_resp_data  out  XLEN  extended load data; 0 for stores.
- mem_req  out  1  memory request.
- mem_we  out  1  write.
- mem_addr  out  ADDR_W  word address; bits [1:0] are 0.
- mem_be  out  4  byte enables; 4'hF for reads.
- mem_wdata  out  XLEN  lane-steered store data.
- mem_gnt  in  1  memory accepted mem_req this cycle.
- mem_rvalid  in  1  read data or write ack; exactly one per grant.
- mem_rdata  in  XLEN  read word.

Behaviour:
- FSM states (t_arb_state): IDLE, REQ, WAIT, RESP. Owner register (t_arb_owner): OWN_IF, OWN_D.
- Reset: state=IDLE, last_owner=OWN_IF. All outputs 0 except mem_be=0.
- Readies: if_req_ready and d_req_ready are asserted only in IDLE, and never both in the same cycle.
- Arbitration in IDLE:
  - Only one requester valid: it wins.
  - Both valid: the requester that did not win the previous transaction wins (last-grant-loses). After reset, D wins a tie.
  - On winning, address, fcn, typ and wdata are latched, owner is set, and state goes to REQ.
- REQ: mem_req=1 with latched fields, held stable until mem_gnt. On mem_gnt, go to WAIT. mem_req may stay high indefinitely.
- WAIT: mem_req=0. On mem_rvalid, capture data and go to RESP. A mem_rvalid arriving in the same cycle as mem_gnt is illegal for the memory; the bench flags it.
- RESP: exactly one cycle. The owner's resp_valid=1 with registered data; last_owner is updated; go to IDLE.
- Minimum latency (gnt same cycle, rvalid next cycle): accept t0, mem_req t1, rvalid t2, resp_valid t3. Back-to-back acceptance is possible at t4.
- Store steering (by d_req_addr[1:0]):
  - MT_B: mem_be=4'b0001<<a[1:0]; wdata byte replicated x4.
  - MT_H: mem_be=4'b0011<<{a[1],1'b0}; halfword replicated x2.
  - MT_W/MT_WU/MT_D/MT_X: mem_be=4'hF, wdata unchanged.
- Load extraction: select byte or half by a[1:0].
  - MT_B/MT_H: sign-extend.
  - MT_BU/MT_HU: zero-extend.
  - Others: full word.
- mem_rvalid outside WAIT is ignored. Request inputs are ignored outside IDLE.
- Reset in any state aborts the transaction; no response pulse is produced. A mem_rvalid belonging to the aborted transaction is discarded.

Optional Feature:
- Macro: MEM_PORT_ARBITER_ALIGN_CHECK_EN.
- Defined:
  - Adds output port d_resp_err (1 bit; reset 0).
  - A D request that is MT_H/MT_HU with a[0]=1, or MT_W with a[1:0]!=0, goes IDLE->RESP directly, with no memory transaction.
  - That response has d_resp_valid=1, d_resp_err=1, d_resp_data=0.
  - d_resp_err is 0 on all other responses.
- Undefined: no port. Misaligned accesses use the steering above with low address bits dropped (word-aligned access).

Decomposition:
- Add t_arb_state (IDLE, REQ, WAIT, RESP) and t_arb_owner (OWN_IF, OWN_D) to consts; reuse t_m and t_mt.
- Sub-module mem_lane_align (combinational):
  - Store direction: typ, addr[1:0], wdata -> be, steered wdata.
  - Load direction: typ, addr[1:0], rdata -> extended data.
  - Instantiated once; the FSM stays in mem_port_arbiter.

Test Plan:
- Fetch only: if addr 0x100, mem returns 0x00500093 with gnt immediate, rvalid next cycle -> if_resp_valid exactly at t3, data 0x00500093, mem_be=4'hF.
- Simultaneous IF and D (M_XRD, MT_W, 0x200) right after reset -> D granted first; IF granted next; a following tie alternates back to D.
- Store MT_B 0xAB at 0x203 -> mem_addr 0x200, mem_be 4'b1000, mem_wdata 0xABABABAB, d_resp_valid once with data 0.
- Load MT_H at 0x202, rdata 0x8001_1234 -> d_resp_data 0xFFFF8001. Same with MT_HU -> 0x00008001.
- mem_gnt held low for 5 cycles -> mem_req and fields stable for all 5 cycles, both readies low. Assert rst in WAIT, then pulse rvalid -> no resp pulse, FSM in IDLE.
- With MEM_PORT_ARBITER_ALIGN_CHECK_EN: MT_W load at 0x101 -> mem_req never asserted, d_resp_valid+d_resp_err at t1.
